// File: rtl/gru_seq_driver.sv
// Sequence controller around an external single-step GRU cell: feeds x_t and h_{t-1},
// waits out the cell latency, then emits h_t and recirculates it for the next step.
module gru_seq_driver #(
    parameter int INT_WIDTH  = 4,
    parameter int FRAC_WIDTH = 10,
    parameter int WIDTH      = INT_WIDTH + FRAC_WIDTH + 1,
    parameter int CELL_LAT   = 1,
    parameter int LEN_W      = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [LEN_W-1:0]     seq_len,
    input  logic                 h_init_en,
    input  logic [4*WIDTH-1:0]   h_init,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*WIDTH-1:0]   in_x,
    output logic [4*WIDTH-1:0]   cell_x,
    output logic [4*WIDTH-1:0]   cell_h,
    input  logic [4*WIDTH-1:0]   cell_y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*WIDTH-1:0]   out_h,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done
);
    localparam int VW   = 4 * WIDTH;
    localparam int WC_W = $clog2(CELL_LAT + 1);

    typedef enum logic [1:0] {IDLE, ACCEPT, WAIT, EMIT} state_t;

    state_t            state_reg, state_next;
    logic [LEN_W-1:0]  len_reg, len_next;
    logic [LEN_W-1:0]  step_reg, step_next;
    logic [WC_W-1:0]   wcnt_reg, wcnt_next;
    logic [VW-1:0]     h_reg, h_next;
    logic [VW-1:0]     cell_x_reg, cell_x_next;
    logic [VW-1:0]     cell_h_reg, cell_h_next;
    logic [VW-1:0]     out_h_reg, out_h_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic              last_step;

    // len_reg is never 0 while a sequence runs, so len-1 cannot underflow.
    assign last_step = (step_reg == (len_reg - LEN_W'(1)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= IDLE;
            len_reg    <= '0;
            step_reg   <= '0;
            wcnt_reg   <= '0;
            h_reg      <= '0;
            cell_x_reg <= '0;
            cell_h_reg <= '0;
            out_h_reg  <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            len_reg    <= len_next;
            step_reg   <= step_next;
            wcnt_reg   <= wcnt_next;
            h_reg      <= h_next;
            cell_x_reg <= cell_x_next;
            cell_h_reg <= cell_h_next;
            out_h_reg  <= out_h_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        len_next    = len_reg;
        step_next   = step_reg;
        wcnt_next   = wcnt_reg;
        h_next      = h_reg;
        cell_x_next = cell_x_reg;
        cell_h_next = cell_h_reg;
        out_h_next  = out_h_reg;
        busy_next   = busy_reg;
        done_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (seq_len == '0) begin
                        done_next = 1'b1;
                    end else begin
                        len_next    = seq_len;
                        h_next      = h_init_en ? h_init : '0;
                        cell_h_next = h_init_en ? h_init : '0;
                        step_next   = '0;
                        busy_next   = 1'b1;
                        state_next  = ACCEPT;
                    end
                end
            end
            ACCEPT: begin
                if (in_valid) begin
                    cell_x_next = in_x;
                    wcnt_next   = WC_W'(CELL_LAT);
                    state_next  = WAIT;
                end
            end
            WAIT: begin
                // Capture lands CELL_LAT+1 edges after the accept edge.
                if (wcnt_reg != '0) begin
                    wcnt_next = wcnt_reg - WC_W'(1);
                end else begin
                    h_next     = cell_y;
                    out_h_next = cell_y;
                    state_next = EMIT;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    cell_h_next = h_reg;
                    if (last_step) begin
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        step_next  = step_reg + LEN_W'(1);
                        state_next = ACCEPT;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign in_ready  = (state_reg == ACCEPT);
    assign out_valid = (state_reg == EMIT);
    assign out_last  = (state_reg == EMIT) && last_step;
    assign cell_x    = cell_x_reg;
    assign cell_h    = cell_h_reg;
    assign out_h     = out_h_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
endmodule

// File: tb/tb_gru_seq_driver.sv
// Bench for gru_seq_driver with a stub cell (y = h + x per lane, CELL_LAT stages)
// and a lane-wise running-sum reference for the expected hidden state.
module tb_gru_seq_driver;
    localparam int WIDTH    = 15;
    localparam int CELL_LAT = 3;
    localparam int LEN_W    = 16;
    localparam int VW       = 4 * WIDTH;

    typedef logic [VW-1:0] vec_t;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             start = 1'b0;
    logic [LEN_W-1:0] seq_len = '0;
    logic             h_init_en = 1'b0;
    vec_t             h_init = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    vec_t             in_x = '0;
    vec_t             cell_x, cell_h, cell_y, out_h;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic             out_last, busy, done;

    int   total = 0;
    int   bad   = 0;
    vec_t exp_h = '0;

    gru_seq_driver #(
        .INT_WIDTH(4), .FRAC_WIDTH(10), .WIDTH(WIDTH), .CELL_LAT(CELL_LAT), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .seq_len(seq_len),
        .h_init_en(h_init_en), .h_init(h_init), .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .cell_x(cell_x), .cell_h(cell_h), .cell_y(cell_y),
        .out_valid(out_valid), .out_ready(out_ready), .out_h(out_h),
        .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic vec_t lane_add(input vec_t a, input vec_t b);
        vec_t r;
        for (int i = 0; i < 4; i++) r[i*WIDTH +: WIDTH] = a[i*WIDTH +: WIDTH] + b[i*WIDTH +: WIDTH];
        return r;
    endfunction

    function automatic vec_t splat(input logic [WIDTH-1:0] v);
        return {v, v, v, v};
    endfunction

    function automatic vec_t rand_vec();
        return vec_t'({$urandom(), $urandom()});
    endfunction

    // Stub cell
    vec_t pipe [CELL_LAT];
    always_ff @(posedge clk) begin
        pipe[0] <= lane_add(cell_h, cell_x);
        for (int k = 1; k < CELL_LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign cell_y = pipe[CELL_LAT-1];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic start_seq(input int len, input logic hen, input vec_t hinit);
        start = 1'b1; seq_len = LEN_W'(len); h_init_en = hen; h_init = hinit;
        exp_h = hen ? hinit : '0;
        @(negedge clk);
        start = 1'b0; seq_len = LEN_W'($urandom_range(1, 9)); h_init = rand_vec();
        check("busy_after_start", busy, 1'b1);
    endtask

    task automatic do_step(input int t, input int len, input vec_t x, input int stall_n, input bit stray);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        check("in_ready", in_ready, 1'b1);
        in_valid = 1'b1; in_x = x; out_ready = (stall_n == 0);
        @(negedge clk);
        in_x = ~x;  // stray data during WAIT/EMIT must not be taken
        n = 1;
        while (!out_valid && n < 40) begin
            check("in_ready_wait", in_ready, 1'b0);
            start = (stray && n == 1);
            seq_len = LEN_W'(len + 5);
            @(negedge clk); n++;
        end
        start = 1'b0;
        check("accept_to_valid", n, CELL_LAT + 2);
        check("cell_h_prev", cell_h, exp_h);
        check("cell_x", cell_x, x);
        exp_h = lane_add(exp_h, x);
        check("out_h", out_h, exp_h);
        check("out_last", out_last, (t == len - 1));
        $display("step %0d/%0d x=%h h=%h last=%0b", t, len, x, out_h, out_last);
        repeat (stall_n) begin
            @(negedge clk);
            check("stall_valid", out_valid, 1'b1);
            check("stall_out_h", out_h, exp_h);
            check("stall_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        if (t == len - 1) begin
            check("done_pulse", done, 1'b1);
            check("busy_fall", busy, 1'b0);
            check("valid_after", out_valid, 1'b0);
            check("out_h_hold", out_h, exp_h);
            check("cell_h_final", cell_h, exp_h);
            in_valid = 1'b0;
            @(negedge clk);
            check("done_one_cycle", done, 1'b0);
        end else begin
            check("done_mid", done, 1'b0);
            check("cell_h_fb", cell_h, exp_h);
        end
    endtask

    task automatic run_seq(input int len, input logic hen, input vec_t hinit, input bit fixed,
                           input vec_t fx, input int stall_step, input int stall_n, input int stray_step);
        start_seq(len, hen, hinit);
        for (int t = 0; t < len; t++)
            do_step(t, len, fixed ? fx : rand_vec(), (t == stall_step) ? stall_n : 0, t == stray_step);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t prev;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_out_h", out_h, '0);
        check("rst_cell_h", cell_h, '0);
        check("rst_cell_x", cell_x, '0);
        reset_n = 1'b1;
        @(negedge clk);

        // Running sum from h_init 0x0400 with x 0x0100
        run_seq(3, 1'b1, splat(15'h0400), 1'b1, splat(15'h0100), -1, 0, -1);
        check("seq1_final", out_h, splat(15'h0700));

        // Zero initial state
        run_seq(2, 1'b0, rand_vec(), 1'b1, splat(15'h0200), -1, 0, -1);
        check("seq2_final", out_h, splat(15'h0400));

        // Backpressure on the first step, stray start while busy on step 1
        run_seq(3, 1'b1, rand_vec(), 1'b0, '0, 0, 10, 1);

        // Zero-length sequence
        prev = out_h;
        start = 1'b1; seq_len = '0; h_init_en = 1'b1; h_init = rand_vec();
        @(negedge clk);
        start = 1'b0;
        check("len0_done", done, 1'b1);
        check("len0_busy", busy, 1'b0);
        check("len0_in_ready", in_ready, 1'b0);
        check("len0_out_h", out_h, prev);
        @(negedge clk);
        check("len0_done_clear", done, 1'b0);
        check("len0_in_ready2", in_ready, 1'b0);
        $display("len0 start done pulse seen");

        // Randomized sequences
        repeat (5) begin
            int len;
            len = $urandom_range(1, 5);
            run_seq(len, 1'(($urandom % 2)), rand_vec(), 1'b0, '0,
                    $urandom_range(0, len - 1), $urandom_range(0, 4), $urandom_range(0, len));
        end

        // Reset during WAIT of step 2 of 4
        start_seq(4, 1'b1, rand_vec());
        do_step(0, 4, rand_vec(), 0, 1'b0);
        do_step(1, 4, rand_vec(), 0, 1'b0);
        check("rst_mid_ready", in_ready, 1'b1);
        in_valid = 1'b1; in_x = rand_vec();
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("rstmid_in_ready", in_ready, 1'b0);
        check("rstmid_out_valid", out_valid, 1'b0);
        check("rstmid_busy", busy, 1'b0);
        check("rstmid_done", done, 1'b0);
        check("rstmid_out_h", out_h, '0);
        check("rstmid_cell_h", cell_h, '0);
        check("rstmid_cell_x", cell_x, '0);
        @(negedge clk);
        check("rstmid_no_done", done, 1'b0);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_done", done, 1'b0);
        $display("reset mid-sequence applied");
        run_seq(3, 1'b1, rand_vec(), 1'b0, '0, -1, 0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
